pool1_seq: RTL
==============

// Module: pool1_seq
// PURPOSE
//  Upstream sequencer for the 2x2 max-pool stage. Accepts the conv1 output
//  stream in raster order. Each beat is one pixel carrying two packed signed
//  16-bit channels. Applies optional ReLU, then drives the pool stage's
//  v/indata/dtype/ar inputs with window-position and line-buffer addressing.
//  Also supplies the pooled-output pixel index that goes with each pool result.
// PARAMETERS
//  IMG_W    24  conv1 map width in pixels; even, 2..2**AR_W
//  IMG_H    24  conv1 map height in pixels; even, >=2
//  AR_W     10  width of the ar column address
//  RELU_EN  1   1: clamp each negative 16-bit half to 0 before output
// PORTS
//  clk       in   1     clock
//  rst       in   1     reset, asynchronous, active-high
//  start     in   1     1-cycle pulse; begins one frame
//  s_valid   in   1     input beat valid
//  s_ready   out  1     input beat accepted when s_valid&s_ready
//  s_data    in   32    {ch0[31:16], ch1[15:0]}, signed
//  v         out  1     pool-stage beat valid
//  indata    out  32    processed pixel pair to pool stage
//  dtype     out  2     {row[0], col[0]} of the beat
//  ar        out  AR_W  column index of the beat; pool uses ar[AR_W-1:1]
//  opix      out  16    pooled pixel index (row/2)*(IMG_W/2)+col/2
//  busy      out  1     frame in progress
//  done      out  1     1-cycle pulse after the last beat leaves on v
// BEHAVIOUR
//  - All outputs are registered. Reset values: s_ready 0, v 0, indata 0,
//    dtype 0, ar 0, opix 0, busy 0, done 0. Reset clears the row/col counters.
//  - FSM IDLE -> RUN -> LAST -> IDLE.
//    IDLE: start -> RUN; counters cleared to 0.
//    RUN: s_ready=1 except in the cycle after the final beat is accepted.
//         Accepting the beat at row IMG_H-1, col IMG_W-1 -> LAST.
//    LAST: v for the final beat is high; done=1 on the next cycle; -> IDLE.
//  - start is ignored outside IDLE. busy=1 in RUN and LAST.
//  - Latency is exactly 1 cycle: a beat accepted in cycle n gives v=1 in n+1.
//    indata, dtype, ar and opix in that cycle use the counters at acceptance.
//  - The stage has no backpressure: one beat in per cycle, one beat out.
//    A gap on s_valid gives v=0 in that cycle; indata, dtype, ar and opix
//    hold their previous values.
//  - Counters: col wraps IMG_W-1 -> 0 and increments row. row stops at IMG_H-1.
//    ar = col, zero-extended to AR_W.
//  - ReLU: each 16-bit half is handled separately. If bit 15 is set the half
//    becomes 16'h0000; otherwise it passes unchanged. With RELU_EN=0 the data
//    passes unchanged.
//  - opix is computed for every beat. It is meaningful to consumers only when
//    dtype==2'b11, which is when the pool stage asserts d_valid.
//  - Reset mid-frame aborts the frame: FSM to IDLE, no done pulse.
//  - An illegal IMG_W/IMG_H (odd, or IMG_W > 2**AR_W) triggers an
//    elaboration-time $error.
// STRUCTURE
//  - A shared package pool_pkg holds:
//    typedef pix2_t (2x logic signed [15:0]); localparam DT_R0C0..DT_R1C1;
//    the FSM enum seq_state_e.
//  - One sub-module, raster_cnt: a parameterised col/row counter with
//    wrap, last_col and last_pix flags. It is reused by the later pool stages.
// TESTING
//  - IMG_W=4, IMG_H=2, 8 back-to-back beats:
//    dtype 00,01,00,01,10,11,10,11; ar 0,1,2,3,0,1,2,3;
//    opix 0,0,1,1,0,0,1,1; done exactly 2 cycles after the last accepted beat.
//  - RELU_EN=1, s_data=32'h8001_7FFF -> indata=32'h0000_7FFF.
//    RELU_EN=0 -> indata=32'h8001_7FFF.
//  - Gaps on s_valid (alternate 1/0): v follows with 1-cycle lag, held
//    outputs stay stable, and col advances only on accepted beats.
//  - start pulse during RUN: no effect on counters; beat count per frame
//    stays IMG_W*IMG_H (576 for the defaults).
//  - rst asserted after 10 beats: all outputs go to reset values immediately.
//    A new start then begins at row 0, col 0.
//  - End-to-end with pool1 on a 24x24 ramp: 144 d_valid results, each equal
//    to the 2x2 window max (after ReLU), with opix 0..143 in order.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the pool1 sequencer and the later pool stages.
package pool_pkg;

   // One pixel: two packed signed 16-bit channels, ch0 in the upper half.
   typedef struct packed {
      logic signed [15:0] ch0;
      logic signed [15:0] ch1;
   } pix2_t;

   // Window position codes carried on dtype as {row[0], col[0]}.
   localparam logic [1:0] DT_R0C0 = 2'b00;
   localparam logic [1:0] DT_R0C1 = 2'b01;
   localparam logic [1:0] DT_R1C0 = 2'b10;
   localparam logic [1:0] DT_R1C1 = 2'b11;

   // Frame sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2
   } seq_state_e;

   // Clamp each negative half of a pixel pair to zero independently.
   function automatic pix2_t relu_pix(input pix2_t p);
      pix2_t r;
      if (p.ch0[15]) begin
         r.ch0 = 16'sh0000;
      end else begin
         r.ch0 = p.ch0;
      end
      if (p.ch1[15]) begin
         r.ch1 = 16'sh0000;
      end else begin
         r.ch1 = p.ch1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pool1_seq_raster_cnt.sv
// Raster-order column/row counter with wrap and end-of-line/end-of-frame flags.
// The row counter saturates at the last row; a clear restarts the frame.
module raster_cnt #(
   parameter int W  = 24,
   parameter int H  = 24,
   parameter int CW = 10,
   parameter int RW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          last_col_o,
   output logic          last_pix_o
);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          last_row_s;

   assign last_col_o = (col_q == CW'(W - 1));
   assign last_row_s = (row_q == RW'(H - 1));
   assign last_pix_o = last_col_o & last_row_s;
   assign col_o      = col_q;
   assign row_o      = row_q;

   // Next-count: clear wins, otherwise advance one pixel on inc.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (last_col_o) begin
            col_d = '0;
            if (last_row_s) begin
               row_d = row_q;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
            row_d = row_q;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/pool1_seq.sv
// Upstream sequencer for the 2x2 max-pool stage: takes the conv1 raster
// stream, applies optional ReLU and tags each beat with window position,
// column address and pooled output index, all one cycle after acceptance.
module pool1_seq
   import pool_pkg::*;
#(
   parameter int IMG_W   = 24,
   parameter int IMG_H   = 24,
   parameter int AR_W    = 10,
   parameter bit RELU_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [31:0]     s_data,
   output logic            v,
   output logic [31:0]     indata,
   output logic [1:0]      dtype,
   output logic [AR_W-1:0] ar,
   output logic [15:0]     opix,
   output logic            busy,
   output logic            done
);

   localparam int ROW_W = 16;

   if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2 ||
       IMG_W > (2 ** AR_W)) begin : g_bad_geometry
      $error("pool1_seq: illegal geometry IMG_W=%0d IMG_H=%0d AR_W=%0d",
             IMG_W, IMG_H, AR_W);
   end

   seq_state_e      state_q, state_d;
   logic            s_ready_q, v_q, busy_q, done_q;
   logic [31:0]     indata_q;
   logic [1:0]      dtype_q;
   logic [AR_W-1:0] ar_q;
   logic [15:0]     opix_q;

   logic            acc_s, cnt_clr_s, final_beat_s;
   logic [AR_W-1:0] col_s;
   logic [ROW_W-1:0] row_s;
   logic            last_col_s, last_pix_s;
   pix2_t           pix_in_s, pix_out_s;
   logic [15:0]     opix_s;

   // s_ready is only ever high in RUN, so it alone qualifies acceptance.
   assign acc_s        = s_valid & s_ready_q;
   assign cnt_clr_s    = (state_q == ST_IDLE) & start;
   assign final_beat_s = acc_s & last_col_s & last_pix_s;

   raster_cnt #(
      .W  (IMG_W),
      .H  (IMG_H),
      .CW (AR_W),
      .RW (ROW_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr_s),
      .inc_i      (acc_s),
      .col_o      (col_s),
      .row_o      (row_s),
      .last_col_o (last_col_s),
      .last_pix_o (last_pix_s)
   );

   assign pix_in_s  = pix2_t'(s_data);
   assign pix_out_s = RELU_EN ? relu_pix(pix_in_s) : pix_in_s;
   assign opix_s    = 16'(row_s >> 1) * 16'(IMG_W / 2) + 16'(col_s >> 1);

   // Frame FSM: start only matters in IDLE; LAST is the cycle the final beat is on v.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (final_beat_s) begin
               state_d = ST_LAST;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_LAST: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output registers; beat payload only updates on an accepted beat and holds across gaps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ready_q <= 1'b0;
         v_q       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         indata_q  <= 32'h0000_0000;
         dtype_q   <= 2'b00;
         ar_q      <= '0;
         opix_q    <= 16'h0000;
      end else begin
         s_ready_q <= (state_d == ST_RUN);
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_q == ST_LAST);
         v_q       <= acc_s;
         if (acc_s) begin
            indata_q <= pix_out_s;
            dtype_q  <= {row_s[0], col_s[0]};
            ar_q     <= col_s;
            opix_q   <= opix_s;
         end
      end
   end

   assign s_ready = s_ready_q;
   assign v       = v_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign indata  = indata_q;
   assign dtype   = dtype_q;
   assign ar      = ar_q;
   assign opix    = opix_q;

endmodule
